// File: rtl/trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the machine-mode trap sequencer:
//   - data path width
//   - mcause exception / interrupt codes
//   - sequencer FSM state encoding
//   - mtvec MODE field encodings
//   - trap_target(): computes the trap entry PC from mtvec and the cause
// ---------------------------------------------------------------------------
package trap_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  // Synchronous exception codes (mcause.interrupt = 0)
  localparam logic [3:0] EXC_FETCH_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
  localparam logic [3:0] EXC_BREAK          = 4'd3;
  localparam logic [3:0] EXC_ECALL_M        = 4'd11;

  // Machine interrupt codes (mcause.interrupt = 1)
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // mtvec MODE field
  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP_WR  = 2'd1,
    ST_TRAP_JMP = 2'd2,
    ST_MRET_JMP = 2'd3
  } trap_state_e;

  // Trap entry PC. Only interrupts are vectored; exceptions always land on
  // the base address even when mtvec selects vectored mode. The add wraps
  // naturally at DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] trap_target(
    input logic [DATA_WIDTH-1:0] mtvec,
    input logic [3:0]            cause,
    input logic                  is_irq,
    input logic                  vec_en
  );
    logic [DATA_WIDTH-1:0] w_base;
    w_base = {mtvec[DATA_WIDTH-1:2], 2'b00};
    if (vec_en && is_irq && (mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
      return w_base + DATA_WIDTH'({cause, 2'b00});
    end
    return w_base;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Combinational interrupt qualifier and priority encoder.
// An interrupt line qualifies when its mie & mip pair is set, the global
// mstatus.MIE bit is set and no CSR write is in flight.
// Priority: external (11) > software (3) > timer (7).
// Ports:
//   i_mstatus_ie               global machine interrupt enable
//   i_csr_busy                 CSR write in EX/WB, blocks acceptance
//   i_mie_* / i_mip_*          per-source enable / pending bits
//   o_irq_valid                some interrupt qualifies
//   o_irq_cause                mcause code of the winning interrupt
// ---------------------------------------------------------------------------
module irq_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic       i_mstatus_ie,
  input  logic       i_csr_busy,
  input  logic       i_mie_external,
  input  logic       i_mie_software,
  input  logic       i_mie_timer,
  input  logic       i_mip_external,
  input  logic       i_mip_software,
  input  logic       i_mip_timer,
  output logic       o_irq_valid,
  output logic [3:0] o_irq_cause
);

  logic w_global_ok;
  logic w_ext;
  logic w_sw;
  logic w_tmr;

  assign w_global_ok = i_mstatus_ie & ~i_csr_busy;
  assign w_ext       = w_global_ok & i_mie_external & i_mip_external;
  assign w_sw        = w_global_ok & i_mie_software & i_mip_software;
  assign w_tmr       = w_global_ok & i_mie_timer    & i_mip_timer;

  always_comb begin
    o_irq_valid = 1'b0;
    o_irq_cause = 4'd0;
    if (w_ext) begin
      o_irq_valid = 1'b1;
      o_irq_cause = IRQ_MEI;
    end else if (w_sw) begin
      o_irq_valid = 1'b1;
      o_irq_cause = IRQ_MSI;
    end else if (w_tmr) begin
      o_irq_valid = 1'b1;
      o_irq_cause = IRQ_MTI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap sequencer between EX and the CSR file. Accepts one
// event per IDLE cycle (exception > mret > interrupt) and runs:
//   trap : T stall, T+1 CSR strobes + stall, T+2 flush + redirect to mtvec
//   mret : T stall, T+1 mstatus set + flush + redirect to mepc
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   inst_valid_i, pc_i                EX instruction valid / PC
//   exc_valid_i, exc_code_i, mret_i   EX exception / mret indication
//   csr_busy_i                        blocks interrupt acceptance
//   mstatus_ie_i, mie_*_i, mip_*_i    interrupt enable / pending bits
//   mtvec_i, epc_i                    trap vector and mepc from CSR file
//   cause_we_o, interrupt_type_o,
//   cause_o, epc_we_o, epc_o          mcause / mepc update
//   mstatus_ie_clear_o/_set_o         trap entry / mret strobes
//   stall_o, flush_o                  pipeline control
//   redirect_valid_o, redirect_pc_o   PC redirect
// ---------------------------------------------------------------------------
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int VECTORED_EN = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inst_valid_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  exc_valid_i,
  input  logic [3:0]            exc_code_i,
  input  logic                  mret_i,
  input  logic                  csr_busy_i,
  input  logic                  mstatus_ie_i,
  input  logic                  mie_external_i,
  input  logic                  mie_timer_i,
  input  logic                  mie_software_i,
  input  logic                  mip_external_i,
  input  logic                  mip_timer_i,
  input  logic                  mip_software_i,
  input  logic [DATA_WIDTH-1:0] mtvec_i,
  input  logic [DATA_WIDTH-1:0] epc_i,
  output logic                  cause_we_o,
  output logic                  interrupt_type_o,
  output logic [3:0]            cause_o,
  output logic                  epc_we_o,
  output logic [DATA_WIDTH-1:0] epc_o,
  output logic                  mstatus_ie_clear_o,
  output logic                  mstatus_ie_set_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  redirect_valid_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o
);

  trap_state_e           r_state;
  logic [3:0]            r_cause;
  logic                  r_irq;
  logic [DATA_WIDTH-1:0] r_epc;
  logic                  r_cause_we;
  logic                  r_epc_we;
  logic                  r_ie_clear;
  logic                  r_ie_set;
  logic                  r_flush;
  logic                  r_redirect_valid;
  logic [DATA_WIDTH-1:0] r_redirect_pc;

  logic                  w_irq_valid;
  logic [3:0]            w_irq_cause;
  logic                  w_idle;
  logic                  w_take_exc;
  logic                  w_take_mret;
  logic                  w_take_irq;
  logic                  w_accept;

  irq_prio_enc u_irq_prio_enc (
    .i_mstatus_ie   (mstatus_ie_i),
    .i_csr_busy     (csr_busy_i),
    .i_mie_external (mie_external_i),
    .i_mie_software (mie_software_i),
    .i_mie_timer    (mie_timer_i),
    .i_mip_external (mip_external_i),
    .i_mip_software (mip_software_i),
    .i_mip_timer    (mip_timer_i),
    .o_irq_valid    (w_irq_valid),
    .o_irq_cause    (w_irq_cause)
  );

  // Acceptance decode with fixed priority: exception > mret > interrupt.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_take_exc  = w_idle & inst_valid_i & exc_valid_i;
  assign w_take_mret = w_idle & inst_valid_i & ~exc_valid_i & mret_i;
  assign w_take_irq  = w_idle & inst_valid_i & ~exc_valid_i & ~mret_i & w_irq_valid;
  assign w_accept    = w_take_exc | w_take_mret | w_take_irq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= ST_IDLE;
      r_cause          <= 4'd0;
      r_irq            <= 1'b0;
      r_epc            <= '0;
      r_cause_we       <= 1'b0;
      r_epc_we         <= 1'b0;
      r_ie_clear       <= 1'b0;
      r_ie_set         <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      // All strobes are single-cycle pulses; the redirect PC reads 0
      // whenever redirect_valid is low.
      r_cause_we       <= 1'b0;
      r_epc_we         <= 1'b0;
      r_ie_clear       <= 1'b0;
      r_ie_set         <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;

      case (r_state)
        ST_IDLE: begin
          if (w_take_exc || w_take_irq) begin
            r_cause    <= w_take_exc ? exc_code_i : w_irq_cause;
            r_irq      <= w_take_irq;
            r_epc      <= pc_i;
            r_cause_we <= 1'b1;
            r_epc_we   <= 1'b1;
            r_ie_clear <= 1'b1;
            r_state    <= ST_TRAP_WR;
          end else if (w_take_mret) begin
            r_ie_set         <= 1'b1;
            r_flush          <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= epc_i;
            r_state          <= ST_MRET_JMP;
          end
        end
        ST_TRAP_WR: begin
          r_flush          <= 1'b1;
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= trap_target(mtvec_i, r_cause, r_irq, (VECTORED_EN != 0));
          r_state          <= ST_TRAP_JMP;
        end
        ST_TRAP_JMP: r_state <= ST_IDLE;
        ST_MRET_JMP: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall covers the accept cycle and, for traps, the CSR-write cycle.
  assign stall_o            = (w_idle & w_accept) | (r_state == ST_TRAP_WR);

  assign cause_we_o         = r_cause_we;
  assign interrupt_type_o   = r_irq;
  assign cause_o            = r_cause;
  assign epc_we_o           = r_epc_we;
  assign epc_o              = r_epc;
  assign mstatus_ie_clear_o = r_ie_clear;
  assign mstatus_ie_set_o   = r_ie_set;
  assign flush_o            = r_flush;
  assign redirect_valid_o   = r_redirect_valid;
  assign redirect_pc_o      = r_redirect_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
// Directed self-checking bench for trap_ctrl. Inputs change on the falling
// edge; outputs are checked 1 time unit after that, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic        mret;
  logic        csr_busy;
  logic        mstatus_ie;
  logic        mie_ext, mie_tmr, mie_sw;
  logic        mip_ext, mip_tmr, mip_sw;
  logic [31:0] mtvec;
  logic [31:0] epc_in;

  logic        cause_we;
  logic        irq_type;
  logic [3:0]  cause;
  logic        epc_we;
  logic [31:0] epc_out;
  logic        ie_clear;
  logic        ie_set;
  logic        stall;
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_pc;

  int total = 0;
  int bad   = 0;

  trap_ctrl #(.VECTORED_EN(1)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .inst_valid_i       (inst_valid),
    .pc_i               (pc),
    .exc_valid_i        (exc_valid),
    .exc_code_i         (exc_code),
    .mret_i             (mret),
    .csr_busy_i         (csr_busy),
    .mstatus_ie_i       (mstatus_ie),
    .mie_external_i     (mie_ext),
    .mie_timer_i        (mie_tmr),
    .mie_software_i     (mie_sw),
    .mip_external_i     (mip_ext),
    .mip_timer_i        (mip_tmr),
    .mip_software_i     (mip_sw),
    .mtvec_i            (mtvec),
    .epc_i              (epc_in),
    .cause_we_o         (cause_we),
    .interrupt_type_o   (irq_type),
    .cause_o            (cause),
    .epc_we_o           (epc_we),
    .epc_o              (epc_out),
    .mstatus_ie_clear_o (ie_clear),
    .mstatus_ie_set_o   (ie_set),
    .stall_o            (stall),
    .flush_o            (flush),
    .redirect_valid_o   (redir_valid),
    .redirect_pc_o      (redir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then settle.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ex();
    inst_valid = 1'b0;
    exc_valid  = 1'b0;
    exc_code   = 4'd0;
    mret       = 1'b0;
  endtask

  // Trap-entry CSR strobe cycle (T+1).
  task automatic chk_strobes(input string tag, input logic [3:0] c, input logic t, input logic [31:0] e);
    chk({tag, ".cause_we"}, cause_we, 1);
    chk({tag, ".epc_we"},   epc_we,   1);
    chk({tag, ".ie_clear"}, ie_clear, 1);
    chk({tag, ".cause"},    cause,    c);
    chk({tag, ".type"},     irq_type, t);
    chk({tag, ".epc"},      epc_out,  e);
    chk({tag, ".stall1"},   stall,    1);
    chk({tag, ".noredir1"}, redir_valid, 0);
    $display("txn %s strobes cause=%0d type=%0d epc=%h", tag, cause, irq_type, epc_out);
  endtask

  // Trap redirect cycle (T+2).
  task automatic chk_jump(input string tag, input logic [31:0] tgt);
    chk({tag, ".flush"},  flush,       1);
    chk({tag, ".redir"},  redir_valid, 1);
    chk({tag, ".pc"},     redir_pc,    tgt);
    chk({tag, ".stall2"}, stall,       0);
    chk({tag, ".cwe2"},   cause_we,    0);
    $display("txn %s redirect pc=%h", tag, redir_pc);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".q_redir"}, redir_valid, 0);
    chk({tag, ".q_pc"},    redir_pc,    0);
    chk({tag, ".q_flush"}, flush,       0);
    chk({tag, ".q_cwe"},   cause_we,    0);
    chk({tag, ".q_set"},   ie_set,      0);
  endtask

  initial begin
    rst = 1'b1;
    clear_ex();
    pc = 32'h0; csr_busy = 1'b0; mstatus_ie = 1'b0;
    mie_ext = 0; mie_tmr = 0; mie_sw = 0;
    mip_ext = 0; mip_tmr = 0; mip_sw = 0;
    mtvec = 32'h0; epc_in = 32'h0;

    // ---- reset state
    cyc(); cyc();
    chk("rst.stall", stall, 0);
    chk("rst.cause", cause, 0);
    chk("rst.epc",   epc_out, 0);
    chk("rst.type",  irq_type, 0);
    chk("rst.clr",   ie_clear, 0);
    chk_quiet("rst");
    rst = 1'b0;
    cyc();
    $display("txn reset done");

    // ---- ecall, direct mtvec
    inst_valid = 1; exc_valid = 1; exc_code = 4'd11; pc = 32'h100; mtvec = 32'h800;
    #1; chk("ecall.stallT", stall, 1);
    cyc(); clear_ex(); #1;
    chk_strobes("ecall", 4'd11, 1'b0, 32'h100);
    cyc(); chk_jump("ecall", 32'h800);
    cyc(); chk_quiet("ecall.T3");

    // ---- timer interrupt, vectored mtvec
    mstatus_ie = 1; mie_tmr = 1; mip_tmr = 1; mtvec = 32'h801;
    inst_valid = 1; pc = 32'h200;
    #1; chk("tmr.stallT", stall, 1);
    cyc(); clear_ex(); #1;
    chk_strobes("tmr", 4'd7, 1'b1, 32'h200);
    cyc(); chk_jump("tmr", 32'h81C);
    mip_tmr = 0;
    cyc(); chk_quiet("tmr.T3");

    // ---- all three pending; masked by mstatus_ie, then by csr_busy
    mie_ext = 1; mie_sw = 1; mie_tmr = 1; mip_ext = 1; mip_sw = 1; mip_tmr = 1;
    mstatus_ie = 0; inst_valid = 1; pc = 32'h240;
    #1; chk("mask_ie.stall", stall, 0);
    cyc(); chk("mask_ie.cwe", cause_we, 0);
    mstatus_ie = 1; csr_busy = 1;
    #1; chk("busy.stall", stall, 0);
    cyc(); chk("busy.cwe", cause_we, 0);
    csr_busy = 0;
    #1; chk("all3.stallT", stall, 1);
    cyc(); clear_ex(); #1;
    chk_strobes("all3", 4'd11, 1'b1, 32'h240);
    cyc(); chk_jump("all3", 32'h82C);
    mip_ext = 0; mip_sw = 0;
    cyc(); chk_quiet("all3.T3");

    // ---- illegal + timer in same cycle: exception wins, no vectoring
    inst_valid = 1; exc_valid = 1; exc_code = 4'd2; pc = 32'h300;
    #1; chk("ill.stallT", stall, 1);
    cyc(); clear_ex(); #1;
    chk_strobes("ill", 4'd2, 1'b0, 32'h300);
    cyc(); chk_jump("ill", 32'h800);
    cyc(); chk_quiet("ill.T3");

    // ---- handler mret with timer still pending
    inst_valid = 1; mret = 1; epc_in = 32'h300;
    #1; chk("mret.stallT", stall, 1);
    cyc(); clear_ex(); #1;
    chk("mret.set",   ie_set, 1);
    chk("mret.flush", flush, 1);
    chk("mret.redir", redir_valid, 1);
    chk("mret.pc",    redir_pc, 32'h300);
    chk("mret.stall1", stall, 0);
    chk("mret.cwe",   cause_we, 0);
    $display("txn mret redirect pc=%h", redir_pc);
    cyc();
    // T+2: back in IDLE, timer accepted immediately
    inst_valid = 1; pc = 32'h300;
    #1; chk("post_mret.stallT", stall, 1);
    cyc(); clear_ex(); #1;
    chk_strobes("post_mret", 4'd7, 1'b1, 32'h300);
    cyc(); chk_jump("post_mret", 32'h81C);
    mip_tmr = 0;
    cyc(); chk_quiet("post_mret.T3");

    // ---- reset asserted in TRAP_WR
    inst_valid = 1; exc_valid = 1; exc_code = 4'd3; pc = 32'h400; mtvec = 32'h800;
    cyc(); clear_ex(); #1;
    chk("rstwr.cwe_before", cause_we, 1);
    rst = 1;
    cyc();
    rst = 0; #1;
    chk("rstwr.cause", cause, 0);
    chk("rstwr.epc",   epc_out, 0);
    chk("rstwr.stall", stall, 0);
    chk("rstwr.clr",   ie_clear, 0);
    chk_quiet("rstwr");
    cyc(); chk_quiet("rstwr.after");
    $display("txn reset in TRAP_WR");

    // ---- reset asserted in TRAP_JMP
    inst_valid = 1; exc_valid = 1; exc_code = 4'd0; pc = 32'h500;
    cyc(); clear_ex();
    cyc();
    chk("rstjmp.redir_before", redir_valid, 1);
    rst = 1;
    cyc();
    rst = 0; #1;
    chk("rstjmp.cause", cause, 0);
    chk("rstjmp.epc",   epc_out, 0);
    chk("rstjmp.stall", stall, 0);
    chk_quiet("rstjmp");
    cyc(); chk_quiet("rstjmp.after");
    $display("txn reset in TRAP_JMP");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer sitting between the execute stage and the CSR file. It arbitrates between synchronous exceptions, `mret` and the three machine interrupts (external, software, timer). For each accepted event it runs a fixed multi-cycle sequence: it drives the CSR file's mcause/mepc/mstatus update strobes, stalls the pipeline, then issues one flush plus a PC redirect to the trap vector or to mepc.

## Interface
Parameters:
- `VECTORED_EN`, default 1: when 1, honour mtvec MODE=01 for interrupts; when 0, always use direct mode.

Ports:
- `clk_i`  in  1  single clock
- `rst_i`  in  1  reset; synchronous and active-high
- `inst_valid_i`  in  1  valid instruction in EX this cycle
- `pc_i`  in  `DATA_WIDTH`  PC of that EX instruction
- `exc_valid_i`  in  1  EX instruction raises a synchronous exception
- `exc_code_i`  in  4  exception code (0 misaligned fetch, 2 illegal, 3 ebreak, 11 ecall)
- `mret_i`  in  1  EX instruction is `mret`
- `csr_busy_i`  in  1  a CSR write is in EX/WB; interrupt acceptance is blocked
- `mstatus_ie_i`, `mie_external_i`, `mie_timer_i`, `mie_software_i`  in  1 each  enable bits from the CSR file
- `mip_external_i`, `mip_timer_i`, `mip_software_i`  in  1 each  pending bits from the CSR file
- `mtvec_i`  in  `DATA_WIDTH`  trap vector from the CSR file
- `epc_i`  in  `DATA_WIDTH`  mepc from the CSR file
- `cause_we_o`, `interrupt_type_o`  out  1 each  mcause write strobe and mcause interrupt bit
- `cause_o`  out  4  mcause code
- `epc_we_o`  out  1  mepc write strobe
- `epc_o`  out  `DATA_WIDTH`  value written to mepc
- `mstatus_ie_clear_o`, `mstatus_ie_set_o`  out  1 each  trap entry / `mret` strobes
- `stall_o`  out  1  freeze IF/ID/EX
- `flush_o`  out  1  kill IF/ID/EX contents
- `redirect_valid_o`  out  1  load the PC with `redirect_pc_o`
- `redirect_pc_o`  out  `DATA_WIDTH`  redirect target

## Operation
- FSM states: IDLE, TRAP_WR, TRAP_JMP, MRET_JMP.
- In IDLE, when `inst_valid_i` is high, one event is accepted with this priority:
  - exception (`exc_valid_i`), then `mret_i`, then interrupt.
  - An interrupt qualifies only when `mstatus_ie_i` is 1, the matching mie&mip pair is 1, and `csr_busy_i` is 0.
  - Interrupt priority: external (cause 11), then software (3), then timer (7).
- Exception accepted: latch cause=`exc_code_i`, interrupt_type=0, epc=`pc_i`; go to TRAP_WR.
- Interrupt accepted: latch the winning cause, interrupt_type=1, epc=`pc_i` (the EX instruction is killed and not retired); go to TRAP_WR.
- `mret` accepted: go to MRET_JMP.
- TRAP_WR: pulse `cause_we_o`, `epc_we_o` and `mstatus_ie_clear_o` for one cycle; go to TRAP_JMP.
- TRAP_JMP: pulse `flush_o` and `redirect_valid_o`; go to IDLE.
  - Target is `{mtvec_i[31:2],2'b00}` in direct mode.
  - Target is base + (cause<<2) when `VECTORED_EN`=1, `mtvec_i[1:0]`=01 and the event is an interrupt.
  - Addition is modulo 2^`DATA_WIDTH`.
- MRET_JMP: pulse `mstatus_ie_set_o`, `flush_o` and `redirect_valid_o` with target `epc_i`; go to IDLE.
- No event is accepted outside IDLE. Interrupts are level-sensitive, so a pending one is re-evaluated on the next IDLE cycle.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and the latched cause/epc/type registers reset to 0.
- Accept cycle T (combinational in IDLE):
  - `stall_o`=1 in cycle T.
  - Trap: `stall_o` stays 1 through T+1 and deasserts in T+2.
  - `mret`: `stall_o` is 1 in cycle T only.
- Trap sequence: CSR strobes at T+1; flush + redirect at T+2; FSM back in IDLE at T+3.
- `mret` sequence: set strobe + flush + redirect at T+1; FSM back in IDLE at T+2.
- `redirect_pc_o` and `flush_o` are valid only while `redirect_valid_o`=1. Outside those cycles they read 0.
- Exception and interrupt pending in the same cycle: the exception wins and the interrupt is taken after it returns, unless the handler masks it.
- After `mret`, with mie restored and an interrupt pending, the trap may be accepted on the first IDLE cycle (T+2).
- `rst_i` asserted in any state forces IDLE and zero outputs on the next edge. A sequence interrupted by reset is abandoned, with no partial strobe afterward.

## Structure
- The shared package/defines hold: cause codes (EXC_FETCH_MISALIGN=0, EXC_ILLEGAL=2, EXC_BREAK=3, EXC_ECALL_M=11, IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11), the FSM state encoding, and the mtvec MODE encodings.
- One sub-module, `irq_prio_enc`: a combinational qualifier/priority encoder producing irq_valid and irq_cause[3:0].

## Test plan
- `ecall` at pc=0x0000_0100, mtvec=0x0000_0800: strobes at T+1 with cause=11, type=0, epc=0x100; redirect to 0x800 at T+2.
- Timer irq with mie_timer=1, mstatus_ie=1, mtvec=0x0000_0801, pc=0x200: cause=7, type=1, epc=0x200; redirect to 0x81C.
- External + software + timer all pending: cause=11 is taken first. With mstatus_ie low or `csr_busy_i`=1, no acceptance occurs.
- Illegal instruction and timer irq in the same cycle: cause=2 is taken. After handler `mret` with epc=0x300, `mstatus_ie_set_o` pulses and the redirect goes to 0x300; the timer trap (cause 7) is accepted at T+2.
- Assert `rst_i` in TRAP_WR and in TRAP_JMP: all outputs 0 on the next cycle, FSM in IDLE, no redirect issued.
